// File: rtl/load_store_unit.sv
// Load/store unit: CPU-side initiator for a word-wide RISC-V data memory.
// Accepts one request at a time. Requests are validated before memory is
// touched. Sub-word stores are performed as read-modify-write. Results are
// returned over a valid/ready response channel.
module load_store_unit #(
    parameter int MEM_WORDS = 64,
    parameter int IDX_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [1:0]           resp_cause,
    output logic                 MemWrite,
    output logic                 MemRread,
    output logic [IDX_WIDTH-1:0] mem_index,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          MemData_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3  = 2'b10;
    localparam logic [1:0] CAUSE_RANGE   = 2'b11;

    state_t                 state;

    // A captured request waits one cycle in IDLE before it is dispatched.
    logic                   pending;
    logic                   store_q;
    logic [2:0]             funct3_q;
    logic [1:0]             lane_q;
    logic [IDX_WIDTH-1:0]   index_q;
    logic [31:0]            wdata_q;
    logic [1:0]             cause_q;

    logic                   funct3_legal;
    logic                   misaligned;
    logic                   out_of_range;
    logic [1:0]             req_cause;

    // Pick the addressed byte or halfword out of a memory word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overwrite one byte or halfword lane of the old word with new store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] new_data,
                                                input logic        is_byte,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = old_word;
        if (is_byte) begin
            r[{lane, 3'b000} +: 8] = new_data[7:0];
        end else begin
            r[{lane[1], 4'b0000} +: 16] = new_data[15:0];
        end
        return r;
    endfunction

    // Validate the incoming request: funct3 first, then alignment, then range.
    always_comb begin
        funct3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
            3'b100, 3'b101:         funct3_legal = !req_store;
            default:                funct3_legal = 1'b0;
        endcase

        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

        req_cause = CAUSE_NONE;
        if (!funct3_legal) begin
            req_cause = CAUSE_FUNCT3;
        end else if (misaligned) begin
            req_cause = CAUSE_MISALGN;
        end else if (out_of_range) begin
            req_cause = CAUSE_RANGE;
        end
    end

    // Memory strobes come straight from the state register, so they are
    // mutually exclusive and low whenever the FSM sits in reset or IDLE.
    assign MemRread  = (state == RD);
    assign MemWrite  = (state == WR);
    assign req_ready = (state == IDLE) && !pending;

    // Main FSM: capture, dispatch, memory access and response handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            index_q    <= '0;
            wdata_q    <= 32'd0;
            cause_q    <= CAUSE_NONE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            resp_cause <= CAUSE_NONE;
            mem_index  <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pending) begin
                        if (req_valid) begin
                            pending  <= 1'b1;
                            store_q  <= req_store;
                            funct3_q <= req_funct3;
                            lane_q   <= req_addr[1:0];
                            index_q  <= req_addr[IDX_WIDTH+1:2];
                            wdata_q  <= req_wdata;
                            cause_q  <= req_cause;
                        end
                    end else begin
                        pending <= 1'b0;
                        if (cause_q != CAUSE_NONE) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_cause <= cause_q;
                            resp_rdata <= 32'd0;
                        end else begin
                            mem_index <= index_q;
                            if (store_q && (funct3_q[1:0] == 2'b10)) begin
                                mem_wdata <= wdata_q;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end

                RD: begin
                    if (store_q) begin
                        mem_wdata <= merge_store(MemData_out, wdata_q,
                                                 (funct3_q[1:0] == 2'b00), lane_q);
                        state     <= WR;
                    end else begin
                        resp_rdata <= extract_load(MemData_out, funct3_q, lane_q);
                        resp_err   <= 1'b0;
                        resp_cause <= CAUSE_NONE;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end

                WR: begin
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    resp_cause <= CAUSE_NONE;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus a random
// request stream compared against a byte-addressed reference memory.
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;
    localparam int IDX_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_store;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [1:0]           resp_cause;
    logic                 MemWrite;
    logic                 MemRread;
    logic [IDX_WIDTH-1:0] mem_index;
    logic [31:0]          mem_wdata;
    logic [31:0]          MemData_out;

    // Word memory the DUT talks to, and the byte-level reference copy.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic [7:0]  ref_mem [0:4*MEM_WORDS-1];

    logic                 pre_we;
    logic [IDX_WIDTH-1:0] pre_idx;
    logic [31:0]          pre_data;

    int pass_cnt = 0;
    int total_cnt = 0;
    int overlap_cnt = 0;

    int          lat, rd_n, wr_n;
    logic [IDX_WIDTH-1:0] last_idx;
    logic [31:0] last_wdata;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [1:0]  got_cause;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_cause(resp_cause),
        .MemWrite(MemWrite), .MemRread(MemRread), .mem_index(mem_index),
        .mem_wdata(mem_wdata), .MemData_out(MemData_out)
    );

    always #5 clk = ~clk;

    // Combinational-read, synchronous-write data memory with a preload port.
    assign MemData_out = mem[mem_index];
    always @(posedge clk) begin
        if (MemWrite) mem[mem_index] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    // Count cycles where both memory strobes are high.
    always @(negedge clk) begin
        if (MemWrite && MemRread) overlap_cnt++;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference behaviour derived from access size and RISC-V load/store rules.
    task automatic model_access(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] w,
                                output logic [1:0] cause, output logic [31:0] rdata,
                                output int elat, output int erd, output int ewr);
        logic legal;
        int size;
        int base;
        logic [31:0] val;
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        rdata = 32'd0; erd = 0; ewr = 0; elat = 1; cause = 2'b00;
        if (!legal) cause = 2'b10;
        else if ((a % 32'(size)) != 0) cause = 2'b01;
        else if ((a / 4) >= 32'(MEM_WORDS)) cause = 2'b11;
        else begin
            base = int'(a);
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[base+i] = w[8*i +: 8];
                elat = (size == 4) ? 2 : 3;
                erd  = (size == 4) ? 0 : 1;
                ewr  = 1;
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(ref_mem[base+i]) << (8*i));
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                rdata = val;
                elat = 2;
                erd  = 1;
            end
        end
    endtask

    // Drive one request once the LSU is ready; returns #1 after the accept edge.
    task automatic send_req(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] w);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = w;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count edges until resp_valid, logging memory strobes along the way.
    task automatic wait_resp();
        lat = 0; rd_n = 0; wr_n = 0;
        while (!resp_valid && lat < 20) begin
            if (MemRread) rd_n++;
            if (MemWrite) begin
                wr_n++; last_idx = mem_index; last_wdata = mem_wdata;
            end
            @(posedge clk); #1; lat++;
        end
        got_rdata = resp_rdata; got_err = resp_err; got_cause = resp_cause;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b0;
        for (int w = 0; w < MEM_WORDS; w++) begin
            pre_we = 1'b1; pre_idx = IDX_WIDTH'(w);
            pre_data = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        total_cnt++; if ({MemWrite, MemRread} !== 2'b00) $display("[TB] FAIL strobes_in_reset: got %b want 00", {MemWrite, MemRread}); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err, resp_cause} !== 4'b0000) $display("[TB] FAIL reset_resp: got %b want 0000", {resp_valid, resp_err, resp_cause}); else pass_cnt++;
        total_cnt++; if (resp_rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h want 0", resp_rdata); else pass_cnt++;

        send_req(1'b0, 3'b010, 32'h10, 32'd0);
        @(posedge clk); #1;
        total_cnt++; if (MemRread !== 1'b1) $display("[TB] FAIL abort_in_rd: got MemRread %b want 1", MemRread); else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        total_cnt++; if ({req_ready, MemRread, resp_valid} !== 3'b100) $display("[TB] FAIL abort_state: got %b want 100", {req_ready, MemRread, resp_valid}); else pass_cnt++;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("[TB] FAIL abort_no_resp: got resp seen %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_word_store_load();
        logic [1:0] ec; logic [31:0] er; int el, erd, ewr;
        model_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, ec, er, el, erd, ewr);
        send_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        wait_resp();
        total_cnt++; if (lat !== 2) $display("[TB] FAIL sw_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if ({rd_n, wr_n} !== {32'd0, 32'd1}) $display("[TB] FAIL sw_strobes: got rd %0d wr %0d want rd 0 wr 1", rd_n, wr_n); else pass_cnt++;
        total_cnt++; if ({last_idx, last_wdata} !== {6'd4, 32'hDEADBEEF}) $display("[TB] FAIL sw_write: got idx %0d data %h want idx 4 data deadbeef", last_idx, last_wdata); else pass_cnt++;
        total_cnt++; if ({got_err, got_rdata} !== 33'd0) $display("[TB] FAIL sw_resp: got err %b rdata %h want 0/0", got_err, got_rdata); else pass_cnt++;
        ack_resp();
        model_access(1'b0, 3'b010, 32'h10, 32'd0, ec, er, el, erd, ewr);
        send_req(1'b0, 3'b010, 32'h10, 32'd0);
        wait_resp();
        total_cnt++; if ({got_err, got_rdata} !== {1'b0, 32'hDEADBEEF}) $display("[TB] FAIL lw_data: got err %b rdata %h want 0/deadbeef", got_err, got_rdata); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("[TB] FAIL lw_latency: got %0d want 2", lat); else pass_cnt++;
        ack_resp();
    endtask

    task automatic test_subword_rmw();
        logic [1:0] ec; logic [31:0] er; int el, erd, ewr;
        logic [2:0]  ld_f3  [0:2];
        logic [31:0] ld_exp [0:2];
        ld_f3[0] = 3'b000; ld_exp[0] = 32'hFFFFFFAB;
        ld_f3[1] = 3'b100; ld_exp[1] = 32'h000000AB;
        ld_f3[2] = 3'b001; ld_exp[2] = 32'h000011AB;
        model_access(1'b1, 3'b010, 32'h10, 32'h11223344, ec, er, el, erd, ewr);
        send_req(1'b1, 3'b010, 32'h10, 32'h11223344);
        wait_resp();
        ack_resp();
        model_access(1'b1, 3'b000, 32'h12, 32'h000000AB, ec, er, el, erd, ewr);
        send_req(1'b1, 3'b000, 32'h12, 32'h000000AB);
        wait_resp();
        total_cnt++; if ({rd_n, wr_n} !== {32'd1, 32'd1}) $display("[TB] FAIL sb_strobes: got rd %0d wr %0d want 1/1", rd_n, wr_n); else pass_cnt++;
        total_cnt++; if (last_wdata !== 32'h11AB3344) $display("[TB] FAIL sb_merge: got %h want 11ab3344", last_wdata); else pass_cnt++;
        total_cnt++; if (lat !== 3) $display("[TB] FAIL sb_latency: got %0d want 3", lat); else pass_cnt++;
        ack_resp();
        for (int i = 0; i < 3; i++) begin
            model_access(1'b0, ld_f3[i], 32'h12, 32'd0, ec, er, el, erd, ewr);
            send_req(1'b0, ld_f3[i], 32'h12, 32'd0);
            wait_resp();
            total_cnt++; if (got_rdata !== ld_exp[i] || er !== ld_exp[i]) $display("[TB] FAIL subword_load_%0d: got %h model %h want %h", i, got_rdata, er, ld_exp[i]); else pass_cnt++;
            ack_resp();
        end
    endtask

    task automatic test_errors();
        logic [1:0] ec; logic [31:0] er; int el, erd, ewr;
        logic        e_st   [0:2];
        logic [2:0]  e_f3   [0:2];
        logic [31:0] e_addr [0:2];
        logic [1:0]  e_exp  [0:2];
        e_st[0] = 1'b0; e_f3[0] = 3'b010; e_addr[0] = 32'h13;  e_exp[0] = 2'b01;
        e_st[1] = 1'b1; e_f3[1] = 3'b101; e_addr[1] = 32'h10;  e_exp[1] = 2'b10;
        e_st[2] = 1'b0; e_f3[2] = 3'b010; e_addr[2] = 32'h100; e_exp[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            model_access(e_st[i], e_f3[i], e_addr[i], 32'h5A5A5A5A, ec, er, el, erd, ewr);
            send_req(e_st[i], e_f3[i], e_addr[i], 32'h5A5A5A5A);
            wait_resp();
            total_cnt++; if ({got_err, got_cause, got_rdata} !== {1'b1, e_exp[i], 32'd0}) $display("[TB] FAIL err_resp_%0d: got err %b cause %b rdata %h want 1 %b 0", i, got_err, got_cause, got_rdata, e_exp[i]); else pass_cnt++;
            total_cnt++; if ({lat, rd_n, wr_n} !== {32'd1, 32'd0, 32'd0}) $display("[TB] FAIL err_timing_%0d: got lat %0d rd %0d wr %0d want 1 0 0", i, lat, rd_n, wr_n); else pass_cnt++;
            ack_resp();
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] ec; logic [31:0] er, er2; int el, erd, ewr;
        logic stable;
        model_access(1'b0, 3'b010, 32'h10, 32'd0, ec, er, el, erd, ewr);
        model_access(1'b0, 3'b010, 32'h04, 32'd0, ec, er2, el, erd, ewr);
        send_req(1'b0, 3'b010, 32'h10, 32'd0);
        wait_resp();
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h04; req_wdata = 32'd0;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== er || req_ready !== 1'b0) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("[TB] FAIL bp_hold: got stable %b want 1 (rdata %h want %h)", stable, resp_rdata, er); else pass_cnt++;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total_cnt++; if ({resp_valid, req_ready} !== 2'b01) $display("[TB] FAIL bp_handshake: got valid/ready %b want 01", {resp_valid, req_ready}); else pass_cnt++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total_cnt++; if (req_ready !== 1'b0) $display("[TB] FAIL bp_accept: got req_ready %b want 0", req_ready); else pass_cnt++;
        wait_resp();
        total_cnt++; if ({lat, got_rdata} !== {32'd2, er2}) $display("[TB] FAIL bp_second: got lat %0d rdata %h want 2 %h", lat, got_rdata, er2); else pass_cnt++;
        ack_resp();
    endtask

    task automatic test_random();
        logic st; logic [2:0] f3; logic [31:0] a, w;
        logic [1:0] ec; logic [31:0] er; int el, erd, ewr, k;
        for (int n = 0; n < 500; n++) begin
            st = 1'($urandom_range(0, 1));
            k  = $urandom_range(0, 4);
            if (st) f3 = 3'($urandom_range(0, 2));
            else    f3 = (k < 3) ? 3'(k) : 3'(k + 1);
            if ($urandom_range(0, 19) == 0) f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 15))
                0:       a = 32'h100 + 32'($urandom_range(0, 4095));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 4*MEM_WORDS-1));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            w = $urandom;
            model_access(st, f3, a, w, ec, er, el, erd, ewr);
            send_req(st, f3, a, w);
            wait_resp();
            total_cnt++; if ({got_err, got_cause} !== {(ec != 2'b00), ec}) $display("[TB] FAIL rnd_status_%0d: got err %b cause %b want cause %b", n, got_err, got_cause, ec); else pass_cnt++;
            total_cnt++; if (got_rdata !== er) $display("[TB] FAIL rnd_rdata_%0d: got %h want %h (st %b f3 %b addr %h)", n, got_rdata, er, st, f3, a); else pass_cnt++;
            total_cnt++; if (lat !== el) $display("[TB] FAIL rnd_latency_%0d: got %0d want %0d", n, lat, el); else pass_cnt++;
            total_cnt++; if ({rd_n, wr_n} !== {erd, ewr}) $display("[TB] FAIL rnd_strobes_%0d: got rd %0d wr %0d want rd %0d wr %0d", n, rd_n, wr_n, erd, ewr); else pass_cnt++;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            ack_resp();
        end
        for (int w2 = 0; w2 < MEM_WORDS; w2++) begin
            total_cnt++; if (mem[w2] !== {ref_mem[4*w2+3], ref_mem[4*w2+2], ref_mem[4*w2+1], ref_mem[4*w2]}) $display("[TB] FAIL final_mem_%0d: got %h want %h", w2, mem[w2], {ref_mem[4*w2+3], ref_mem[4*w2+2], ref_mem[4*w2+1], ref_mem[4*w2]}); else pass_cnt++;
        end
        total_cnt++; if (overlap_cnt !== 0) $display("[TB] FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        pre_we = 1'b0; pre_idx = '0; pre_data = 32'd0;
        for (int i = 0; i < 4*MEM_WORDS; i++) ref_mem[i] = 8'($urandom);
        @(posedge clk); #1;
        $display("[TB] starting load_store_unit bench");
        test_reset();
        test_word_store_load();
        test_subword_rmw();
        test_errors();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
